// File: rtl/abr_params_pkg.sv
// Shared ML-KEM / memory sizing constants and the CBD writer state encoding.
package abr_params_pkg;

   localparam int COEFF_PER_CLK      = 4;
   localparam int MLKEM_Q_WIDTH      = 12;
   localparam int MLKEM_N            = 256;
   localparam int ABR_MEM_ADDR_WIDTH = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } cbd_writer_state_e;

endpackage

// File: rtl/cbd_poly_writer_if.sv
// Sequencer/sampler-facing inputs and memory write port of the CBD polynomial writer.
interface cbd_poly_writer_if
   import abr_params_pkg::*;
#(
   parameter int NUM_COEFF = COEFF_PER_CLK,
   parameter int COEFF_W   = MLKEM_Q_WIDTH,
   parameter int ADDR_W    = ABR_MEM_ADDR_WIDTH
);

   logic                           start_i;
   logic [ADDR_W-1:0]              dest_base_addr_i;
   logic                           data_valid_i;
   logic [NUM_COEFF*COEFF_W-1:0]   data_i;
   logic                           mem_we_o;
   logic [ADDR_W-1:0]              mem_addr_o;
   logic [NUM_COEFF*COEFF_W-1:0]   mem_wdata_o;
   logic                           busy_o;
   logic                           done_o;
   logic                           drop_err_o;

   modport master (
      output start_i, dest_base_addr_i, data_valid_i, data_i,
      input  mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, drop_err_o
   );

   modport slave (
      input  start_i, dest_base_addr_i, data_valid_i, data_i,
      output mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, drop_err_o
   );

endinterface

// File: rtl/cbd_poly_writer.sv
// Packs each valid CBD coefficient bundle into one memory word at base+beat.
//
//   state  | meaning
//   IDLE   | waiting for start_i; any valid beat is dropped and flagged
//   ACTIVE | capturing beats into the write stage, counter = next beat index
//   DONE   | last write issued this cycle (done_o); valid beats dropped
module cbd_poly_writer
   import abr_params_pkg::*;
#(
   parameter int NUM_COEFF  = COEFF_PER_CLK,
   parameter int COEFF_W    = MLKEM_Q_WIDTH,
   parameter int ADDR_W     = ABR_MEM_ADDR_WIDTH,
   parameter int POLY_BEATS = MLKEM_N / COEFF_PER_CLK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             zeroize,
   cbd_poly_writer_if.slave bus
);

   localparam int DATA_W = NUM_COEFF * COEFF_W;
   localparam int CNT_W  = (POLY_BEATS > 1) ? $clog2(POLY_BEATS) : 1;

   cbd_writer_state_e   state;
   logic [CNT_W-1:0]    cnt;
   logic [ADDR_W-1:0]   base_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                drop_err_q;

   always_ff @(posedge clk) begin
      if (rst || zeroize) begin
         state      <= IDLE;
         cnt        <= '0;
         base_q     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         drop_err_q <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  base_q     <= bus.dest_base_addr_i;
                  cnt        <= '0;
                  drop_err_q <= 1'b0;
                  state      <= ACTIVE;
               end
               // Placed after the start-clear so a coincident drop still sets the flag.
               if (bus.data_valid_i) begin
                  drop_err_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (bus.data_valid_i) begin
                  we_q    <= 1'b1;
                  addr_q  <= base_q + ADDR_W'(cnt);
                  wdata_q <= bus.data_i;
                  if (cnt == CNT_W'(POLY_BEATS - 1)) begin
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (bus.data_valid_i) begin
                  drop_err_q <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // zeroize must kill the in-flight write immediately, not one cycle later.
   assign bus.mem_we_o    = we_q & ~zeroize;
   assign bus.done_o      = (state == DONE) & ~zeroize;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.busy_o      = (state != IDLE);
   assign bus.drop_err_o  = drop_err_q;

endmodule

// File: tb/tb_cbd_poly_writer.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_cbd_poly_writer;

   localparam int NC = 4;
   localparam int CW = 12;
   localparam int AW = 15;
   localparam int PB = 64;
   localparam int DW = NC * CW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          done;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic zeroize;

   always #5 clk = ~clk;

   cbd_poly_writer_if #(.NUM_COEFF(NC), .COEFF_W(CW), .ADDR_W(AW)) bus ();

   cbd_poly_writer #(
      .NUM_COEFF (NC),
      .COEFF_W   (CW),
      .ADDR_W    (AW),
      .POLY_BEATS(PB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .zeroize(zeroize),
      .bus    (bus.slave)
   );

   int   checks     = 0;
   int   errors     = 0;
   int   cyc        = 0;
   int   writes     = 0;
   int   exp_writes = 0;
   bit   mon_en     = 1'b0;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every issued write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.mem_we_o) begin
            writes++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                        bus.mem_addr_o, bus.mem_wdata_o);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("wr_addr",  64'(bus.mem_addr_o),  64'(e.addr));
               chk("wr_data",  64'(bus.mem_wdata_o), 64'(e.data));
               chk("wr_done",  64'(bus.done_o),      64'(e.done));
               chk("wr_cycle", 64'(cyc),             64'(e.cyc));
            end
         end else if (bus.done_o) begin
            chk("done_without_write", 64'(bus.done_o), 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.done = dn;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      exp_writes++;
   endtask

   // mode 0: beat index in every coefficient; mode 1: {q-2, q-1, 2, 1} pattern.
   task automatic run_poly(input logic [AW-1:0] base, input int duty, input int mode,
                           input bit valid_in_start, input bit valid_in_done);
      logic [CW-1:0] ii;
      logic [DW-1:0] d;
      logic [DW-1:0] ed;
      tick();
      bus.start_i          = 1'b1;
      bus.dest_base_addr_i = base;
      bus.data_valid_i     = valid_in_start;
      bus.data_i           = 48'hABC_ABC_ABC_ABC;
      @(negedge clk);
      chk("busy_in_start", 64'(bus.busy_o), 64'd0);
      for (int i = 0; i < PB; i++) begin
         tick();
         bus.start_i      = 1'b0;
         bus.data_valid_i = 1'b0;
         if (duty < 100) begin
            while ($urandom_range(99) >= duty) begin
               @(negedge clk);
               chk("busy_gap", 64'(bus.busy_o), 64'd1);
               tick();
            end
         end
         ii = CW'(i);
         if (mode == 1) begin
            d  = {12'h001, 12'h002, 12'hD00, 12'hCFF};
            ed = 48'h001_002_D00_CFF;
         end else begin
            d  = {ii, ii, ii, ii};
            ed = {ii, ii, ii, ii};
         end
         bus.data_valid_i = 1'b1;
         bus.data_i       = d;
         push(base + AW'(i), ed, (i == PB - 1));
         @(negedge clk);
         chk("busy_active", 64'(bus.busy_o), 64'd1);
      end
      tick();
      bus.data_valid_i = valid_in_done;
      bus.data_i       = 48'h555_555_555_555;
      @(negedge clk);
      chk("busy_done", 64'(bus.busy_o), 64'd1);
      chk("done_pulse", 64'(bus.done_o), 64'd1);
      tick();
      bus.data_valid_i = 1'b0;
      @(negedge clk);
      chk("busy_after_done", 64'(bus.busy_o), 64'd0);
      chk("done_one_cycle", 64'(bus.done_o), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [CW-1:0] ii;
      rst                  = 1'b1;
      zeroize              = 1'b0;
      bus.start_i          = 1'b0;
      bus.dest_base_addr_i = '0;
      bus.data_valid_i     = 1'b0;
      bus.data_i           = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_we",       64'(bus.mem_we_o),    64'd0);
      chk("rst_addr",     64'(bus.mem_addr_o),  64'd0);
      chk("rst_wdata",    64'(bus.mem_wdata_o), 64'd0);
      chk("rst_busy",     64'(bus.busy_o),      64'd0);
      chk("rst_done",     64'(bus.done_o),      64'd0);
      chk("rst_drop_err", 64'(bus.drop_err_o),  64'd0);
      mon_en = 1'b1;

      run_poly(15'h0100, 100, 0, 1'b0, 1'b0);
      chk("drop_err_clean", 64'(bus.drop_err_o), 64'd0);
      run_poly(15'h0100, 30, 0, 1'b0, 1'b0);
      run_poly(15'h7FF0, 100, 0, 1'b0, 1'b0);
      run_poly(15'h0200, 100, 1, 1'b0, 1'b0);

      // Valid beat while idle is dropped and flagged.
      tick();
      bus.data_valid_i = 1'b1;
      bus.data_i       = 48'h123_456_789_ABC;
      tick();
      bus.data_valid_i = 1'b0;
      @(negedge clk);
      chk("drop_err_idle", 64'(bus.drop_err_o), 64'd1);
      run_poly(15'h0300, 100, 0, 1'b1, 1'b0);
      chk("drop_err_start_valid", 64'(bus.drop_err_o), 64'd1);
      run_poly(15'h0400, 100, 0, 1'b0, 1'b1);
      chk("drop_err_done_valid", 64'(bus.drop_err_o), 64'd1);
      run_poly(15'h0500, 100, 0, 1'b0, 1'b0);
      chk("drop_err_cleared", 64'(bus.drop_err_o), 64'd0);

      // Zeroize at beat 30: the write of beat 29 falls in that cycle and is suppressed.
      tick();
      bus.start_i          = 1'b1;
      bus.dest_base_addr_i = 15'h0600;
      for (int i = 0; i < 30; i++) begin
         tick();
         bus.start_i      = 1'b0;
         ii               = CW'(i);
         bus.data_valid_i = 1'b1;
         bus.data_i       = {ii, ii, ii, ii};
         if (i < 29) push(15'h0600 + AW'(i), {ii, ii, ii, ii}, 1'b0);
      end
      tick();
      zeroize          = 1'b1;
      bus.data_valid_i = 1'b1;
      bus.data_i       = 48'hFFF_FFF_FFF_FFF;
      @(negedge clk);
      chk("zeroize_we_gated", 64'(bus.mem_we_o), 64'd0);
      chk("zeroize_no_done",  64'(bus.done_o),   64'd0);
      tick();
      zeroize          = 1'b0;
      bus.data_valid_i = 1'b0;
      @(negedge clk);
      chk("zeroize_busy", 64'(bus.busy_o),   64'd0);
      chk("zeroize_we",   64'(bus.mem_we_o), 64'd0);
      chk("zeroize_done", 64'(bus.done_o),   64'd0);
      run_poly(15'h0700, 100, 0, 1'b0, 1'b0);

      repeat (3) tick();
      chk("sb_empty",    64'(sb.size()), 64'd0);
      chk("write_count", 64'(writes),    64'(exp_writes));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cbd_poly_writer.md
Name: cbd_poly_writer

Overview:
- Downstream consumer of the CBD sampler control stage.
- Takes the per-clock bundle of CBD coefficients (already reduced mod q) and packs each valid bundle into one memory word.
- Writes MLKEM_N/COEFF_PER_CLK consecutive words starting at a caller-supplied base address.
- Signals completion to the sequencer with a one-cycle done pulse. Flags any valid beat that arrives while no polynomial is in progress.

Parameters:
- NUM_COEFF, default 4 (COEFF_PER_CLK): coefficients per input beat and per memory word.
- COEFF_W, default 12 (MLKEM_Q_WIDTH): bits per coefficient.
- ADDR_W, default 15 (ABR_MEM_ADDR_WIDTH): memory address width.
- POLY_BEATS, default 64 (MLKEM_N/COEFF_PER_CLK): words written per polynomial.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- zeroize  in  1  synchronous clear of all state; same effect as rst.
- start_i  in  1  begin a new polynomial; sampled only in IDLE.
- dest_base_addr_i  in  ADDR_W  first write address; latched when start_i is accepted.
- data_valid_i  in  1  input bundle valid; there is no backpressure.
- data_i  in  NUM_COEFF*COEFF_W  coefficient k occupies bits [k*COEFF_W +: COEFF_W].
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  write address.
- mem_wdata_o  out  NUM_COEFF*COEFF_W  write data; same packing as data_i.
- busy_o  out  1  high in ACTIVE and DONE.
- done_o  out  1  one-cycle pulse, coincident with the last write.
- drop_err_o  out  1  sticky: a valid beat was discarded.

Behaviour:
Interface
- Single clock, clk.
- Reset rst is synchronous and active-high.
- Reset or zeroize: state=IDLE, beat counter=0, base register=0, write stage cleared, drop_err_o=0.
- mem_we_o/mem_addr_o/mem_wdata_o/done_o/busy_o are 0 out of reset.
- zeroize also gates mem_we_o and done_o low combinationally in the same cycle.

State machine
- IDLE:
  - start_i=1: latch dest_base_addr_i, counter=0, clear drop_err_o, go to ACTIVE.
  - data_valid_i in IDLE, including in the start cycle, is dropped and sets drop_err_o. A set wins over the start-clear in the same cycle.
- ACTIVE:
  - Each data_valid_i=1 captures data_i into the write stage, with address = base + counter (mod 2^ADDR_W).
  - The counter increments.
  - When the beat with counter==POLY_BEATS-1 is captured, go to DONE.
  - start_i is ignored in ACTIVE.
  - Gaps in data_valid_i are allowed; the counter holds.
- DONE: lasts exactly one cycle, then returns to IDLE. data_valid_i in this cycle is dropped and sets drop_err_o. start_i in this cycle is ignored.

Write stage and latency
- Registered; latency is exactly 1 cycle.
- mem_we_o is high in the cycle after the capture, with the captured addr/data.
- mem_wdata_o is passed through unmodified, with no value check.
- mem_addr_o and mem_wdata_o hold their last value while mem_we_o=0.
- done_o is asserted in the cycle that issues write POLY_BEATS-1 (that cycle is the DONE state).

Boundary conditions
- Address wrap: base + counter wraps modulo 2^ADDR_W silently.
- Back-to-back polynomials: the earliest new start_i is accepted in the cycle after DONE. Minimum gap between last beat and next first beat is 2 cycles.
- Reset or zeroize mid-polynomial: the remaining writes are abandoned and no done_o is produced. The write issued in that cycle is suppressed.

Decomposition:
- Shared package (abr_params_pkg): COEFF_PER_CLK, MLKEM_Q_WIDTH, MLKEM_N, ABR_MEM_ADDR_WIDTH, and the cbd_writer_state_e enum {IDLE, ACTIVE, DONE}.
- No sub-module; a single FSM + counter + write register is natural.

Test Plan:
- rst; start_i with base=0x0100; 64 consecutive valid beats, data = beat index in every coefficient -> writes at 0x0100..0x013F, each 1 cycle after its beat; done_o only with the 0x013F write; drop_err_o=0.
- Same stimulus with a random valid duty cycle of about 30% -> identical address/data sequence; write count = 64; busy_o high from the cycle after start until after done.
- base=0x7FF0 (ADDR_W=15) -> addresses 0x7FF0..0x7FFF, then wrap to 0x0000..0x002F.
- data_valid_i=1 while IDLE, and in the start cycle -> no mem_we_o; drop_err_o=1 until the next start with no coincident valid.
- zeroize asserted at beat 30 -> no mem_we_o that cycle or after; no done_o; state IDLE. A new start then writes a full 64 beats from the new base.
- Coefficient pattern {q-2, q-1, 2, 1} = {0xCFF, 0xD00, 0x002, 0x001} -> mem_wdata_o = 0x001_002_D00_CFF (coefficient 0 in the LSBs).
